// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// one-bit full-subtract equation used by the datapath cell.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] fullsub_f(input logic a, input logic b, input logic bin);
        logic d;
        logic bo;
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
        return {bo, d};
    endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// One-bit full subtractor: the borrow-path mirror of the full adder.
module serial_sub_fullsub
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic [1:0] res_s;

    // Single-bit difference and borrow.
    always_comb begin
        res_s = fullsub_f(a, b, bin);
        d     = res_s[0];
        bout  = res_s[1];
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor Q = A - B - BIN, LSB first, one bit per clock,
// with a START/BUSY/DONE handshake and results held until the next DONE.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic             BOUT
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_s;
    logic             bo_s;
    logic             load_s;
    logic             last_s;
    logic [WIDTH-1:0] res_next_s;

    serial_sub_fullsub u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (d_s),
        .bout (bo_s)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            res_sr_q <= {WIDTH{1'b0}};
            br_q     <= 1'b0;
            q_q      <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            br_q     <= br_d;
            q_q      <= q_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_d = S_FIN;
                else        state_d = S_RUN;
            end
            S_FIN: begin
                if (START) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BUSY/DONE are decoded from the next state so they leave a flop directly.
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    // Operand capture, per-bit shift/borrow update and final result latch.
    always_comb begin
        load_s     = START && ((state_q == S_IDLE) || (state_q == S_FIN));
        last_s     = (cnt_q == CW'(WIDTH - 1));
        res_next_s = {d_s, res_sr_q[WIDTH-1:1]};
        cnt_d      = cnt_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        res_sr_d   = res_sr_q;
        br_d       = br_q;
        q_d        = q_q;
        bout_d     = bout_q;
        if (load_s) begin
            a_sr_d = A;
            b_sr_d = B;
            br_d   = BIN;
            cnt_d  = {CW{1'b0}};
        end else if (state_q == S_RUN) begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            res_sr_d = res_next_s;
            br_d     = bo_s;
            cnt_d    = cnt_q + CW'(1);
            if (last_s) begin
                q_d    = res_next_s;
                bout_d = bo_s;
            end else begin
                q_d    = q_q;
                bout_d = bout_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Q    = q_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: an 8-bit instance with directed, reset and
// random operations, and a 4-bit instance run exhaustively back-to-back.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, q8o;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, q4o;

    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .Q(q8o), .BOUT(bout8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start4), .A(a4), .B(b4), .BIN(bin4),
        .BUSY(busy4), .DONE(done4), .Q(q4o), .BOUT(bout4)
    );

    // Reference: signed difference, borrow when negative, result reduced mod 2^w.
    function automatic int model(input int w, input int a, input int b, input int bin);
        int m;
        int diff;
        m    = 1 << w;
        diff = a - b - bin;
        return ((diff < 0) ? m : 0) + (((diff % m) + m) % m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle or in its DONE cycle; returns at the DONE cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit hold);
        logic [7:0] q_prev;
        bit ok;
        q_prev = q8o;
        ok     = 1'b1;
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        exp8_q.push_back(9'(model(8, int'(a), int'(b), int'(bin))));
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (hold && i < 8) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end else begin
                start8 = 1'b0;
            end
            if (busy8 !== 1'b1 || done8 !== 1'b0 || q8o !== q_prev) ok = 1'b0;
        end
        check("busy8_window", 32'(ok), 32'd1);
        @(negedge clk);
        check("done8_latency", {30'd0, busy8, done8}, 32'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        bit ok;
        ok     = 1'b1;
        start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        exp4_q.push_back(5'(model(4, int'(a), int'(b), int'(bin))));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4 !== 1'b1 || done4 !== 1'b0) ok = 1'b0;
        end
        check("busy4_window", 32'(ok), 32'd1);
        @(negedge clk);
        check("done4_latency", {30'd0, busy4, done4}, 32'd1);
    endtask

    // Monitors: every DONE pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL done8_unexpected: DONE with no pending operation at %0t", $time);
            end else begin
                check("result8", {23'd0, bout8, q8o}, {23'd0, exp8_q.pop_front()});
            end
        end
        if (rst_n === 1'b1 && done4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL done4_unexpected: DONE with no pending operation at %0t", $time);
            end else begin
                check("result4", {27'd0, bout4, q4o}, {27'd0, exp4_q.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        start4 = 1'b1; a4 = 4'h9; b4 = 4'h3; bin4 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset8_outputs", {21'd0, busy8, done8, bout8, q8o}, 32'd0);
        check("reset4_outputs", {25'd0, busy4, done4, bout4, q4o}, 32'd0);
        rst_n = 1'b1; start8 = 1'b0; start4 = 1'b0;
        @(negedge clk);

        op8(8'h05, 8'h03, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b0);
        start8 = 1'b0;
        @(negedge clk);
        check("idle8_after_fin", {30'd0, busy8, done8}, 32'd0);

        op8(8'h5A, 8'h3C, 1'b1, 1'b1);
        start8 = 1'b0;
        @(negedge clk);

        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset8", {21'd0, busy8, done8, bout8, q8o}, 32'd0);
        @(negedge clk);
        check("reset8_start_held", {21'd0, busy8, done8, bout8, q8o}, 32'd0);
        rst_n = 1'b1; start8 = 1'b0;
        @(negedge clk);
        check("idle8_after_reset", {30'd0, busy8, done8}, 32'd0);
        op8(8'h77, 8'h11, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                start8 = 1'b0;
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));
        start4 = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard8_drained", 32'(exp8_q.size()), 32'd0);
        check("scoreboard4_drained", 32'(exp4_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
